// File: rtl/uart_tx_frame_if.sv
// Parallel-request / serial-line bundle between the pulse generator (master) and
// the UART frame transmitter (slave).
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VLD;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  // DATA_VLD is a one-cycle request; it is taken only when the transmitter is idle.
  // There is no ready: upstream must watch BUSY fall before pulsing again.
  modport master (
    output P_DATA, DATA_VLD, PAR_EN, PAR_TYP,
    input  TX_OUT, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VLD, PAR_EN, PAR_TYP,
    output TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// Define UART_TX_STOP2_EN for a second stop bit.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  uart_tx_frame_if.slave   bus,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_sh;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  parity;
  logic                  tx_d;
  logic                  busy_d;
  logic                  accept;

`ifdef UART_TX_STOP2_EN
  logic                  stop_second_q;
`endif

  assign accept    = (state == IDLE) && bus.DATA_VLD;
  assign parity    = par_typ_q ? ~^data_q : ^data_q;
  assign data_sh   = data_q >> cnt_d;
  assign dbg_state = state;

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      bus.TX_OUT <= 1'b1;
      bus.BUSY   <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop_second_q <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bus.TX_OUT <= tx_d;
      bus.BUSY   <= busy_d;
      if (accept) begin
        data_q    <= bus.P_DATA;
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
      end
`ifdef UART_TX_STOP2_EN
      stop_second_q <= (state == STOP) && !stop_second_q;
`endif
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE:   if (bus.DATA_VLD) state_d = START;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
`ifdef UART_TX_STOP2_EN
        state_d = stop_second_q ? IDLE : STOP;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_sh[0];
      PARITY:  tx_d = parity;
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames plus randomized back-to-back
// frames compared cycle by cycle against a bit-list model of the serial frame.
module tb_uart_tx_frame;

  localparam int W = 8;

  logic       CLK;
  logic       RST;
  logic [2:0] dbg_state;

  uart_tx_frame_if #(.DATA_WIDTH(W)) bus ();

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [0:0] exp_q[$];

  // Frame as a list of line levels: start, data LSB-first, parity, stop bit(s).
  function automatic void build_exp(input logic [W-1:0] d, input logic pe, input logic pt);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) begin
      if (pt) exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
      else    exp_q.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
    end
    exp_q.push_back(1'b1);
`ifdef UART_TX_STOP2_EN
    exp_q.push_back(1'b1);
`endif
  endfunction

  task automatic check_idle(input string name);
    checks++;
    if (bus.TX_OUT !== 1'b1) begin
      errors++;
      $display("FAIL %s idle tx_out: got %b want 1", name, bus.TX_OUT);
    end
    checks++;
    if (bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s idle busy: got %b want 0", name, bus.BUSY);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after the idle check.
  task automatic run_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                           input bit inject, input string name);
    int n;
    build_exp(d, pe, pt);
    n = exp_q.size();
    bus.P_DATA   = d;
    bus.PAR_EN   = pe;
    bus.PAR_TYP  = pt;
    bus.DATA_VLD = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        bus.DATA_VLD = 1'b0;
        bus.P_DATA   = W'($urandom);
        bus.PAR_EN   = 1'($urandom);
        bus.PAR_TYP  = 1'($urandom);
      end
      checks++;
      if (bus.TX_OUT !== exp_q[i]) begin
        errors++;
        $display("FAIL %s bit %0d tx_out: got %b want %b (data=%h pe=%b pt=%b)",
                 name, i, bus.TX_OUT, exp_q[i], d, pe, pt);
      end
      checks++;
      if (bus.BUSY !== 1'b1) begin
        errors++;
        $display("FAIL %s bit %0d busy: got %b want 1", name, i, bus.BUSY);
      end
      if (inject && i == n - 1) begin
        bus.DATA_VLD = 1'b1;
        bus.P_DATA   = '0;
      end
    end
    @(negedge CLK);
    bus.DATA_VLD = 1'b0;
    check_idle(name);
    if (inject) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge CLK);
        check_idle({name, " after ignored request"});
      end
    end
  endtask

  task automatic test_reset();
    RST          = 1'b0;
    bus.DATA_VLD = 1'b1;
    bus.P_DATA   = 8'hAA;
    bus.PAR_EN   = 1'b1;
    bus.PAR_TYP  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check_idle("reset");
    end
    bus.DATA_VLD = 1'b0;
    RST          = 1'b1;
    @(negedge CLK);
    check_idle("reset release");
  endtask

  task automatic test_parity_even();
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5 even");
  endtask

  task automatic test_parity_odd();
    run_frame(8'h01, 1'b1, 1'b1, 1'b0, "01 odd");
    run_frame(8'h01, 1'b1, 1'b0, 1'b0, "01 even");
  endtask

  task automatic test_no_parity_ignore();
    run_frame(8'hFF, 1'b0, 1'b0, 1'b1, "ff nopar");
  endtask

  task automatic test_reset_mid_frame();
    build_exp(8'h96, 1'b1, 1'b0);
    bus.P_DATA   = 8'h96;
    bus.PAR_EN   = 1'b1;
    bus.PAR_TYP  = 1'b0;
    bus.DATA_VLD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (i == 0) bus.DATA_VLD = 1'b0;
      checks++;
      if (bus.TX_OUT !== exp_q[i]) begin
        errors++;
        $display("FAIL mid-reset pre bit %0d tx_out: got %b want %b", i, bus.TX_OUT, exp_q[i]);
      end
    end
    RST = 1'b0;
    @(negedge CLK);
    check_idle("mid-reset abort");
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_idle("mid-reset no resume");
    end
    run_frame(8'h3C, 1'b1, 1'b1, 1'b0, "3c after reset");
  endtask

`ifdef UART_TX_STOP2_EN
  task automatic test_stop2();
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, "55 stop2");
  endtask
`endif

  task automatic test_back_to_back();
    for (int f = 0; f < 24; f++) begin
      run_frame(W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), (f % 5 == 4), "random");
    end
  endtask

  initial begin
    RST          = 1'b0;
    bus.DATA_VLD = 1'b0;
    bus.P_DATA   = '0;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    test_reset();
    test_parity_even();
    test_parity_odd();
    test_no_parity_ignore();
    test_reset_mid_frame();
`ifdef UART_TX_STOP2_EN
    test_stop2();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
